// File: rtl/fpu_types_pkg.sv
// Shared FPU types: operand classes and single-precision field constants.
package fpu_types_pkg;

    localparam int unsigned C_EXP_W   = 8;
    localparam int unsigned C_MANT_W  = 23;
    localparam int unsigned C_BIAS    = 127;
    localparam logic [7:0]  C_EXP_INF = 8'hFF;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_QNAN   = 3'd4,
        CLS_SNAN   = 3'd5
    } fpu_class_t;

    function automatic fpu_class_t fpu_classify(input logic [C_EXP_W-1:0]  e,
                                                input logic [C_MANT_W-1:0] f);
        fpu_class_t c;
        if (e == '0) begin
            c = (f == '0) ? CLS_ZERO : CLS_DENORM;
        end else if (e == C_EXP_INF) begin
            if (f == '0) begin
                c = CLS_INF;
            end else begin
                c = f[C_MANT_W-1] ? CLS_QNAN : CLS_SNAN;
            end
        end else begin
            c = CLS_NORMAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/firstone.sv
// Leading-zero count of a vector; returns G_VECTORLEN when the vector is all zero.
module firstone #(
    parameter int unsigned G_VECTORLEN = 23
) (
    input  logic [G_VECTORLEN-1:0]         vector_i,
    output logic [$clog2(G_VECTORLEN+1)-1:0] lz_o
);

    localparam int unsigned CntW = $clog2(G_VECTORLEN + 1);

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        lz_o = CntW'(G_VECTORLEN);
        for (int unsigned i = 0; i < G_VECTORLEN; i++) begin
            if (vector_i[i]) begin
                lz_o = CntW'(G_VECTORLEN - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpunpack_op.sv
// One-operand unpack datapath: stage 1 classifies and counts leading zeros, stage 2 normalizes.
// Define FPU_UNPACK_FTZ_EN to flush denormals to zero (no LZC or shifter is built).
module fpunpack_op
    import fpu_types_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en1_i,
    input  logic        en2_i,
    input  logic [31:0] op_i,
    output logic        sign_o,
    output logic [9:0]  exp_o,
    output logic [23:0] mant_o,
    output fpu_class_t  class_o
);

    logic                in_sign;
    logic [C_EXP_W-1:0]  in_exp;
    logic [C_MANT_W-1:0] in_frac;
    fpu_class_t          in_cls;

    logic                sign_q;
    logic [C_EXP_W-1:0]  exp_q;
    logic [C_MANT_W-1:0] frac_q;
    fpu_class_t          cls_q;

    logic [9:0]          exp_d;
    logic [23:0]         mant_d;

    assign {in_sign, in_exp, in_frac} = op_i;

`ifdef FPU_UNPACK_FTZ_EN
    always_comb begin
        in_cls = fpu_classify(in_exp, in_frac);
        if (in_cls == CLS_DENORM) begin
            in_cls = CLS_ZERO;
        end
    end
`else
    logic [4:0]  in_lz;
    logic [4:0]  lz_q;
    logic [23:0] norm_mant;

    assign in_cls = fpu_classify(in_exp, in_frac);

    firstone #(
        .G_VECTORLEN(C_MANT_W)
    ) u_lzc (
        .vector_i(in_frac),
        .lz_o    (in_lz)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lz_q <= '0;
        end else if (en1_i) begin
            lz_q <= in_lz;
        end
    end

    // Shift the leading one past the fraction into the hidden-bit position.
    assign norm_mant = {1'b0, frac_q} << (lz_q + 5'd1);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            frac_q <= '0;
            cls_q  <= CLS_ZERO;
        end else if (en1_i) begin
            sign_q <= in_sign;
            exp_q  <= in_exp;
            frac_q <= in_frac;
            cls_q  <= in_cls;
        end
    end

    always_comb begin
        exp_d  = {2'b00, exp_q};
        mant_d = '0;
        unique case (cls_q)
            CLS_NORMAL: mant_d = {1'b1, frac_q};
`ifndef FPU_UNPACK_FTZ_EN
            CLS_DENORM: begin
                mant_d = norm_mant;
                exp_d  = 10'd0 - {5'd0, lz_q};
            end
`endif
            CLS_ZERO:   exp_d  = '0;
            CLS_QNAN,
            CLS_SNAN:   mant_d = {1'b0, frac_q};
            default:    ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_o  <= 1'b0;
            exp_o   <= '0;
            mant_o  <= '0;
            class_o <= CLS_ZERO;
        end else if (en2_i) begin
            sign_o  <= sign_q;
            exp_o   <= exp_d;
            mant_o  <= mant_d;
            class_o <= cls_q;
        end
    end

endmodule

// File: rtl/fpunpack.sv
// Two-operand IEEE single unpacker/pre-normalizer, 2-stage valid/ready pipeline.
// FPU_UNPACK_FTZ_EN selects flush-to-zero handling of denormal operands.
module fpunpack
    import fpu_types_pkg::*;
(
    input  logic        Clk_CI,
    input  logic        Rst_RI,
    input  logic        Flush_SI,
    input  logic        Valid_SI,
    output logic        Ready_SO,
    input  logic [31:0] OpA_DI,
    input  logic [31:0] OpB_DI,
    input  logic [3:0]  OP_SI,
    input  logic [1:0]  RM_SI,
    output logic        Valid_SO,
    input  logic        Ready_SI,
    output logic        SignA_DO,
    output logic        SignB_DO,
    output logic [9:0]  ExpA_DO,
    output logic [9:0]  ExpB_DO,
    output logic [23:0] MantA_DO,
    output logic [23:0] MantB_DO,
    output fpu_class_t  ClassA_DO,
    output fpu_class_t  ClassB_DO,
    output logic [3:0]  OP_SO,
    output logic [1:0]  RM_SO
);

    logic       v1_q, v2_q;
    logic       adv1, adv2;
    logic       en1, en2;
    logic [3:0] op_q;
    logic [1:0] rm_q;

    assign adv2     = ~v2_q | Ready_SI;
    assign adv1     = ~v1_q | adv2;
    assign Ready_SO = adv1;
    assign Valid_SO = v2_q;

    // Data registers only load on real transfers; bubbles leave them untouched.
    assign en1 = adv1 & Valid_SI;
    assign en2 = adv2 & v1_q;

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI || Flush_SI) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (adv1) begin
                v1_q <= Valid_SI;
            end
            if (adv2) begin
                v2_q <= v1_q;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            op_q  <= '0;
            rm_q  <= '0;
            OP_SO <= '0;
            RM_SO <= '0;
        end else begin
            if (en1) begin
                op_q <= OP_SI;
                rm_q <= RM_SI;
            end
            if (en2) begin
                OP_SO <= op_q;
                RM_SO <= rm_q;
            end
        end
    end

    fpunpack_op u_op_a (
        .clk_i  (Clk_CI),
        .rst_i  (Rst_RI),
        .en1_i  (en1),
        .en2_i  (en2),
        .op_i   (OpA_DI),
        .sign_o (SignA_DO),
        .exp_o  (ExpA_DO),
        .mant_o (MantA_DO),
        .class_o(ClassA_DO)
    );

    fpunpack_op u_op_b (
        .clk_i  (Clk_CI),
        .rst_i  (Rst_RI),
        .en1_i  (en1),
        .en2_i  (en2),
        .op_i   (OpB_DI),
        .sign_o (SignB_DO),
        .exp_o  (ExpB_DO),
        .mant_o (MantB_DO),
        .class_o(ClassB_DO)
    );

endmodule

// File: tb/tb_fpunpack.sv
// Directed bench for fpunpack: vector table plus stall, flush and reset sequences.
module tb_fpunpack;
    import fpu_types_pkg::*;

    typedef struct packed {
        logic       s;
        logic [9:0] e;
        logic [23:0] m;
        fpu_class_t c;
    } opres_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        opres_t      ea;
        opres_t      eb;
    } vec_t;

    logic        Clk_CI = 1'b0;
    logic        Rst_RI, Flush_SI, Valid_SI, Ready_SO, Valid_SO, Ready_SI;
    logic [31:0] OpA_DI, OpB_DI;
    logic [3:0]  OP_SI, OP_SO;
    logic [1:0]  RM_SI, RM_SO;
    logic        SignA_DO, SignB_DO;
    logic [9:0]  ExpA_DO, ExpB_DO;
    logic [23:0] MantA_DO, MantB_DO;
    fpu_class_t  ClassA_DO, ClassB_DO;
    opres_t      act_a, act_b;

    int checks = 0;
    int errors = 0;

    always #5 Clk_CI = ~Clk_CI;

    fpunpack dut (
        .Clk_CI   (Clk_CI),
        .Rst_RI   (Rst_RI),
        .Flush_SI (Flush_SI),
        .Valid_SI (Valid_SI),
        .Ready_SO (Ready_SO),
        .OpA_DI   (OpA_DI),
        .OpB_DI   (OpB_DI),
        .OP_SI    (OP_SI),
        .RM_SI    (RM_SI),
        .Valid_SO (Valid_SO),
        .Ready_SI (Ready_SI),
        .SignA_DO (SignA_DO),
        .SignB_DO (SignB_DO),
        .ExpA_DO  (ExpA_DO),
        .ExpB_DO  (ExpB_DO),
        .MantA_DO (MantA_DO),
        .MantB_DO (MantB_DO),
        .ClassA_DO(ClassA_DO),
        .ClassB_DO(ClassB_DO),
        .OP_SO    (OP_SO),
        .RM_SO    (RM_SO)
    );

    assign act_a = '{SignA_DO, ExpA_DO, MantA_DO, ClassA_DO};
    assign act_b = '{SignB_DO, ExpB_DO, MantB_DO, ClassB_DO};

    function automatic opres_t r(input logic s, input logic [9:0] e, input logic [23:0] m,
                                 input fpu_class_t c);
        opres_t x;
        x = '{s, e, m, c};
        return x;
    endfunction

    // Expected result for a denormal input under either build.
    function automatic opres_t dn(input logic s, input logic [9:0] e, input logic [23:0] m);
`ifdef FPU_UNPACK_FTZ_EN
        return r(s, 10'd0, 24'd0, CLS_ZERO);
`else
        return r(s, e, m, CLS_DENORM);
`endif
    endfunction

    function automatic logic [31:0] sop(input int i);
        return {1'b0, 8'(100 + i), 23'(i * 3 + 1)};
    endfunction

    function automatic opres_t sres(input int i);
        return r(1'b0, 10'(100 + i), {1'b1, 23'(i * 3 + 1)}, CLS_NORMAL);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        int lat, sent, recv, seen;
        logic held;
        opres_t saved;

        vecs[0] = '{32'h3F800000, 32'hC0000000,
                    r(0, 10'd127, 24'h800000, CLS_NORMAL), r(1, 10'd128, 24'h800000, CLS_NORMAL)};
        vecs[1] = '{32'h00000001, 32'h00400000,
                    dn(0, 10'h3EA, 24'h800000), dn(0, 10'h000, 24'h800000)};
        vecs[2] = '{32'h7F800000, 32'h7FC00000,
                    r(0, 10'd255, 24'h000000, CLS_INF), r(0, 10'd255, 24'h400000, CLS_QNAN)};
        vecs[3] = '{32'h7F800001, 32'h80000000,
                    r(0, 10'd255, 24'h000001, CLS_SNAN), r(1, 10'd0, 24'h000000, CLS_ZERO)};
        vecs[4] = '{32'h807FFFFF, 32'h00000000,
                    dn(1, 10'h000, 24'hFFFFFE), r(0, 10'd0, 24'h000000, CLS_ZERO)};
        vecs[5] = '{32'h00000300, 32'h7F7FFFFF,
                    dn(0, 10'h3F3, 24'hC00000), r(0, 10'd254, 24'hFFFFFF, CLS_NORMAL)};
        vecs[6] = '{32'hFF800000, 32'hFFFFFFFF,
                    r(1, 10'd255, 24'h000000, CLS_INF), r(1, 10'd255, 24'h7FFFFF, CLS_QNAN)};
        vecs[7] = '{32'h00800000, 32'h00000100,
                    r(0, 10'd1, 24'h800000, CLS_NORMAL), dn(0, 10'h3F2, 24'h800000)};

        Rst_RI = 1'b1; Flush_SI = 1'b0; Valid_SI = 1'b0; Ready_SI = 1'b1;
        OpA_DI = '0; OpB_DI = '0; OP_SI = '0; RM_SI = '0;
        repeat (3) tick();
        Rst_RI = 1'b0;
        #1;
        chk("reset valid_so", 64'(Valid_SO), 64'd0);
        chk("reset ready_so", 64'(Ready_SO), 64'd1);
        chk("reset op a", 64'(act_a), 64'd0);
        chk("reset op b", 64'(act_b), 64'd0);

        // Table: one operand pair at a time, latency and results checked.
        for (int i = 0; i < 8; i++) begin
            Valid_SI = 1'b1; OpA_DI = vecs[i].a; OpB_DI = vecs[i].b;
            OP_SI = 4'(i + 3); RM_SI = 2'(i);
            tick();
            Valid_SI = 1'b0;
            lat = 1;
            while (!Valid_SO && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
            chk($sformatf("vec%0d op a", i), 64'(act_a), 64'(vecs[i].ea));
            chk($sformatf("vec%0d op b", i), 64'(act_b), 64'(vecs[i].eb));
            chk($sformatf("vec%0d op/rm", i), 64'({OP_SO, RM_SO}), 64'({4'(i + 3), 2'(i)}));
        end
        tick();

        // Back-to-back stream with a 3-cycle downstream stall.
        sent = 0; recv = 0; held = 1'b0; saved = '0;
        for (int c = 0; c < 60 && recv < 10; c++) begin
            Valid_SI = (sent < 10);
            OpA_DI = sop(sent); OpB_DI = 32'h0; OP_SI = 4'(sent);
            Ready_SI = !(c >= 4 && c <= 6);
            #1;
            if (c == 5) chk("stall ready_so", 64'(Ready_SO), 64'd0);
            if (held) chk($sformatf("stall hold c%0d", c), 64'({Valid_SO, act_a}),
                          64'({1'b1, saved}));
            held = Valid_SO && !Ready_SI;
            saved = act_a;
            if (Valid_SO && Ready_SI) begin
                chk($sformatf("stream item %0d", recv), 64'({act_a, OP_SO}),
                    64'({sres(recv), 4'(recv)}));
                recv++;
            end
            if (Valid_SI && Ready_SO) sent++;
            tick();
        end
        chk("stream delivered", 64'(recv), 64'd10);
        Valid_SI = 1'b0;
        seen = 0;
        repeat (4) begin
            tick();
            if (Valid_SO) seen++;
        end
        chk("stream no duplicate", 64'(seen), 64'd0);

        // Flush with two operands in flight and a third presented.
        Ready_SI = 1'b0; Valid_SI = 1'b1; OpA_DI = 32'h40000000;
        tick();
        OpA_DI = 32'h40400000;
        tick();
        Flush_SI = 1'b1; OpA_DI = 32'h40800000;
        tick();
        Flush_SI = 1'b0; Valid_SI = 1'b0; Ready_SI = 1'b1;
        #1;
        chk("flush ready_so", 64'(Ready_SO), 64'd1);
        seen = Valid_SO ? 1 : 0;
        repeat (3) begin
            tick();
            if (Valid_SO) seen++;
        end
        chk("flush no valid_so", 64'(seen), 64'd0);
        Valid_SI = 1'b1; OpA_DI = 32'h3F800000; OpB_DI = 32'hC0000000;
        tick();
        Valid_SI = 1'b0;
        tick();
        chk("post-flush valid_so", 64'(Valid_SO), 64'd1);
        chk("post-flush op a", 64'(act_a), 64'(r(0, 10'd127, 24'h800000, CLS_NORMAL)));
        tick();

        // Reset with the pipeline full and downstream stalled.
        Ready_SI = 1'b0; Valid_SI = 1'b1; OpA_DI = 32'h40400000; OpB_DI = 32'h7FC00000;
        OP_SI = 4'hA; RM_SI = 2'd3;
        repeat (2) tick();
        Valid_SI = 1'b0;
        chk("pre-reset full", 64'({Valid_SO, Ready_SO}), 64'b10);
        Rst_RI = 1'b1;
        tick();
        chk("mid reset valid_so", 64'(Valid_SO), 64'd0);
        chk("mid reset outputs", 64'({act_a, OP_SO, RM_SO}), 64'd0);
        chk("mid reset op b", 64'(act_b), 64'd0);
        Rst_RI = 1'b0; Ready_SI = 1'b1;
        seen = 0;
        repeat (3) begin
            tick();
            if (Valid_SO) seen++;
        end
        chk("post-reset no valid_so", 64'(seen), 64'd0);
        chk("post-reset ready_so", 64'(Ready_SO), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
